ptmch_spi_rx: RTL and testbench

- Upstream front end of the pattern-match trigger path, on CLK160M.
- Passively snoops the flash SPI bus (SPI_CS, SPI_CLK, SPI_MOSI). Synchronises and oversamples it, then deframes each CS-low transaction into opcode, 24-bit address and trailing-byte count.
- Emits single-cycle strobes so the trigger/compare stage can match flash commands (program execute, read status, block erase, page data read, write status) against page-address windows without its own bit-level SPI logic.

---
 rtl/ptmch_spi_rx.sv | 271 +++++++++++++++++++++++++++
 tb/tb_ptmch_spi_rx.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptmch_spi_rx.sv
// -----------------------------------------------------------------------------
// ptmch_spi_rx
//
// Passive snooper for the flash SPI bus at the front of the pattern-match
// trigger path. The raw CS/CLK/MOSI lines are synchronised into the CLK160M
// domain and oversampled. Each CS-low transaction is deframed into an opcode,
// an address of P_ADDR_BYTES bytes and a count of the complete data bytes that
// follow. The results are published as single-cycle strobes, so the compare
// stage never has to handle SPI bit timing itself.
//
// Parameters
//   P_SYNC_STG    synchroniser depth for the SPI inputs (>= 2)
//   P_ADDR_BYTES  address bytes after the opcode (1..3); ADDR is
//                 right-justified and zero-filled
//   P_CNT_W       width of the saturating data-byte counter
//
// Ports
//   CLK160M    in   sole clock
//   RESET_N    in   asynchronous active-low reset
//   EN         in   snoop enable; low forces the deframer idle and disarms it
//   SPI_CS     in   raw chip select (active low, asynchronous)
//   SPI_CLK    in   raw SPI clock (mode 0, asynchronous)
//   SPI_MOSI   in   raw SPI data (asynchronous)
//   CS_FALL    out  1-cycle pulse when a frame starts
//   OPCODE     out  last captured opcode
//   OPC_VLD    out  1-cycle pulse, OPCODE updated
//   ADDR       out  last captured address
//   ADDR_VLD   out  1-cycle pulse, ADDR updated
//   DATA_CNT   out  complete data bytes after the address in current/last frame
//   FRAME_END  out  1-cycle pulse when CS rises on a started frame
//   FRAME_ERR  out  1-cycle pulse with FRAME_END when the frame ended off a
//                   byte boundary
// -----------------------------------------------------------------------------
module ptmch_spi_rx #(
    parameter int P_SYNC_STG   = 2,
    parameter int P_ADDR_BYTES = 3,
    parameter int P_CNT_W      = 8
) (
    input  logic               CLK160M,
    input  logic               RESET_N,
    input  logic               EN,
    input  logic               SPI_CS,
    input  logic               SPI_CLK,
    input  logic               SPI_MOSI,
    output logic               CS_FALL,
    output logic [7:0]         OPCODE,
    output logic               OPC_VLD,
    output logic [23:0]        ADDR,
    output logic               ADDR_VLD,
    output logic [P_CNT_W-1:0] DATA_CNT,
    output logic               FRAME_END,
    output logic               FRAME_ERR
);

    // ---------------------------------------------------------------------
    // Local constants
    // ---------------------------------------------------------------------
    localparam int AW   = 8 * P_ADDR_BYTES;       // address field length in bits
    localparam int BC_W = $clog2(AW + 1);         // bit counter must hold AW (>= 8)

    localparam logic [BC_W-1:0]    BC_ONE       = BC_W'(1);
    localparam logic [BC_W-1:0]    BC_OPC_FULL  = BC_W'(8);
    localparam logic [BC_W-1:0]    BC_ADDR_FULL = BC_W'(AW);
    localparam logic [P_CNT_W-1:0] CNT_ONE      = P_CNT_W'(1);
    localparam logic [P_CNT_W-1:0] CNT_MAX      = '1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OPC  = 2'd1;
    localparam logic [1:0] ST_ADDR = 2'd2;
    localparam logic [1:0] ST_DATA = 2'd3;

    // ---------------------------------------------------------------------
    // Input synchronisers
    // All three lines share the same depth, so MOSI at the last stage is
    // the value that was on the wire when the synchronised CLK rose.
    // ---------------------------------------------------------------------
    logic [P_SYNC_STG-1:0] cs_sync_reg;
    logic [P_SYNC_STG-1:0] sclk_sync_reg;
    logic [P_SYNC_STG-1:0] mosi_sync_reg;
    logic [P_SYNC_STG-1:0] cs_sync_next;
    logic [P_SYNC_STG-1:0] sclk_sync_next;
    logic [P_SYNC_STG-1:0] mosi_sync_next;

    genvar gi;
    generate
        for (gi = 0; gi < P_SYNC_STG; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign cs_sync_next[gi]   = SPI_CS;
                assign sclk_sync_next[gi] = SPI_CLK;
                assign mosi_sync_next[gi] = SPI_MOSI;
            end else begin : g_chain
                assign cs_sync_next[gi]   = cs_sync_reg[gi-1];
                assign sclk_sync_next[gi] = sclk_sync_reg[gi-1];
                assign mosi_sync_next[gi] = mosi_sync_reg[gi-1];
            end
        end
    endgenerate

    logic cs_hist_reg;
    logic sclk_hist_reg;

    always_ff @(posedge CLK160M or negedge RESET_N) begin
        if (!RESET_N) begin
            cs_sync_reg   <= '1;          // bus idle: CS deasserted
            sclk_sync_reg <= '0;
            mosi_sync_reg <= '0;
            cs_hist_reg   <= 1'b1;
            sclk_hist_reg <= 1'b0;
        end else begin
            cs_sync_reg   <= cs_sync_next;
            sclk_sync_reg <= sclk_sync_next;
            mosi_sync_reg <= mosi_sync_next;
            cs_hist_reg   <= cs_sync_reg[P_SYNC_STG-1];
            sclk_hist_reg <= sclk_sync_reg[P_SYNC_STG-1];
        end
    end

    logic cs_s;
    logic mosi_s;
    logic cs_fall_det;
    logic cs_rise_det;
    logic sclk_rise_det;

    assign cs_s          = cs_sync_reg[P_SYNC_STG-1];
    assign mosi_s        = mosi_sync_reg[P_SYNC_STG-1];
    assign cs_fall_det   = ~cs_s & cs_hist_reg;
    assign cs_rise_det   = cs_s & ~cs_hist_reg;
    assign sclk_rise_det = sclk_sync_reg[P_SYNC_STG-1] & ~sclk_hist_reg;

    // ---------------------------------------------------------------------
    // Synchroniser fill tracker
    // The CS chain resets to "high", so right after reset the chain still
    // shows idle even if the real bus is mid-frame. Arming is held off
    // until every stage plus the history flop carries a real sample;
    // otherwise a reset released during a frame would see a phantom CS fall
    // and decode the tail of that frame.
    // ---------------------------------------------------------------------
    logic [P_SYNC_STG:0] fill_reg;
    logic                sync_primed;

    always_ff @(posedge CLK160M or negedge RESET_N) begin
        if (!RESET_N) begin
            fill_reg <= '0;
        end else begin
            fill_reg <= {fill_reg[P_SYNC_STG-1:0], 1'b1};
        end
    end

    assign sync_primed = fill_reg[P_SYNC_STG];

    // ---------------------------------------------------------------------
    // Deframer
    // ---------------------------------------------------------------------
    logic [1:0]         state_reg;
    logic               armed_reg;
    logic [BC_W-1:0]    bit_cnt_reg;      // bits in current field (mod 8 in DATA)
    logic [7:0]         opc_sh_reg;
    logic [AW-1:0]      addr_sh_reg;
    logic [7:0]         opcode_reg;
    logic [23:0]        addr_reg;
    logic [P_CNT_W-1:0] data_cnt_reg;
    logic               cs_fall_reg;
    logic               opc_vld_reg;
    logic               addr_vld_reg;
    logic               frame_end_reg;
    logic               frame_err_reg;

    always_ff @(posedge CLK160M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg     <= ST_IDLE;
            armed_reg     <= 1'b0;
            bit_cnt_reg   <= '0;
            opc_sh_reg    <= '0;
            addr_sh_reg   <= '0;
            opcode_reg    <= '0;
            addr_reg      <= '0;
            data_cnt_reg  <= '0;
            cs_fall_reg   <= 1'b0;
            opc_vld_reg   <= 1'b0;
            addr_vld_reg  <= 1'b0;
            frame_end_reg <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            cs_fall_reg   <= 1'b0;
            opc_vld_reg   <= 1'b0;
            addr_vld_reg  <= 1'b0;
            frame_end_reg <= 1'b0;
            frame_err_reg <= 1'b0;

            if (!EN) begin
                // Abort silently; only a fresh CS-high period re-arms.
                state_reg <= ST_IDLE;
                armed_reg <= 1'b0;
            end else begin
                if (sync_primed && cs_s) begin
                    armed_reg <= 1'b1;
                end

                if (state_reg == ST_IDLE) begin
                    if (cs_fall_det && armed_reg) begin
                        state_reg    <= ST_OPC;
                        cs_fall_reg  <= 1'b1;
                        bit_cnt_reg  <= '0;
                        data_cnt_reg <= '0;
                    end
                end else if (cs_rise_det) begin
                    // CS rise has priority over a coincident CLK rise: that
                    // bit never reaches the shifters or the bit counter.
                    state_reg     <= ST_IDLE;
                    frame_end_reg <= 1'b1;
                    frame_err_reg <= (bit_cnt_reg[2:0] != 3'd0);
                end else begin
                    case (state_reg)
                        ST_OPC: begin
                            // Publish one cycle after the 8th bit was shifted.
                            if (bit_cnt_reg == BC_OPC_FULL) begin
                                opcode_reg  <= opc_sh_reg;
                                opc_vld_reg <= 1'b1;
                                bit_cnt_reg <= '0;
                                state_reg   <= ST_ADDR;
                            end else if (sclk_rise_det) begin
                                opc_sh_reg  <= {opc_sh_reg[6:0], mosi_s};
                                bit_cnt_reg <= bit_cnt_reg + BC_ONE;
                            end
                        end
                        ST_ADDR: begin
                            if (bit_cnt_reg == BC_ADDR_FULL) begin
                                // Zero-extension right-justifies short addresses.
                                addr_reg     <= 24'(addr_sh_reg);
                                addr_vld_reg <= 1'b1;
                                bit_cnt_reg  <= '0;
                                state_reg    <= ST_DATA;
                            end else if (sclk_rise_det) begin
                                addr_sh_reg <= {addr_sh_reg[AW-2:0], mosi_s};
                                bit_cnt_reg <= bit_cnt_reg + BC_ONE;
                            end
                        end
                        ST_DATA: begin
                            // Data content is not needed downstream, only
                            // the number of complete bytes.
                            if (sclk_rise_det) begin
                                if (bit_cnt_reg[2:0] == 3'd7) begin
                                    bit_cnt_reg <= '0;
                                    if (data_cnt_reg != CNT_MAX) begin
                                        data_cnt_reg <= data_cnt_reg + CNT_ONE;
                                    end
                                end else begin
                                    bit_cnt_reg <= bit_cnt_reg + BC_ONE;
                                end
                            end
                        end
                        default: begin
                            state_reg <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign CS_FALL   = cs_fall_reg;
    assign OPCODE    = opcode_reg;
    assign OPC_VLD   = opc_vld_reg;
    assign ADDR      = addr_reg;
    assign ADDR_VLD  = addr_vld_reg;
    assign DATA_CNT  = data_cnt_reg;
    assign FRAME_END = frame_end_reg;
    assign FRAME_ERR = frame_err_reg;

endmodule

// File: tb/tb_ptmch_spi_rx.sv
// -----------------------------------------------------------------------------
// tb_ptmch_spi_rx
//
// Drives SPI frames into two instances of ptmch_spi_rx (3-byte and 1-byte
// address variants sharing the same bus) and checks strobe counts and
// captured fields against a frame-level reference model that works from the
// bit list of each frame.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ptmch_spi_rx;

    logic        CLK160M = 1'b0;
    logic        RESET_N = 1'b0;
    logic        EN      = 1'b1;
    logic        SPI_CS  = 1'b1;
    logic        SPI_CLK = 1'b0;
    logic        SPI_MOSI = 1'b0;

    logic        CS_FALL, OPC_VLD, ADDR_VLD, FRAME_END, FRAME_ERR;
    logic [7:0]  OPCODE;
    logic [23:0] ADDR;
    logic [7:0]  DATA_CNT;

    logic        cs_fall1, opc_vld1, addr_vld1, frame_end1, frame_err1;
    logic [7:0]  opcode1;
    logic [23:0] addr1;
    logic [7:0]  data_cnt1;

    ptmch_spi_rx u_dut (
        .CLK160M(CLK160M), .RESET_N(RESET_N), .EN(EN),
        .SPI_CS(SPI_CS), .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI),
        .CS_FALL(CS_FALL), .OPCODE(OPCODE), .OPC_VLD(OPC_VLD),
        .ADDR(ADDR), .ADDR_VLD(ADDR_VLD), .DATA_CNT(DATA_CNT),
        .FRAME_END(FRAME_END), .FRAME_ERR(FRAME_ERR)
    );

    ptmch_spi_rx #(.P_ADDR_BYTES(1)) u_dut1 (
        .CLK160M(CLK160M), .RESET_N(RESET_N), .EN(EN),
        .SPI_CS(SPI_CS), .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI),
        .CS_FALL(cs_fall1), .OPCODE(opcode1), .OPC_VLD(opc_vld1),
        .ADDR(addr1), .ADDR_VLD(addr_vld1), .DATA_CNT(data_cnt1),
        .FRAME_END(frame_end1), .FRAME_ERR(frame_err1)
    );

    always #3.125 CLK160M = ~CLK160M;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- monitor (cumulative event counters) ----------------
    int cyc = 0;
    always @(posedge CLK160M) cyc <= cyc + 1;

    int m_csf = 0, m_opc = 0, m_addr = 0, m_fend = 0, m_ferr = 0, m_ovl = 0;
    int m_opc_cyc = 0;
    int m1_opc = 0, m1_addr = 0, m1_fend = 0, m1_ferr = 0, m1_ovl = 0;

    always @(negedge CLK160M) begin
        if (CS_FALL)   m_csf++;
        if (OPC_VLD)   begin m_opc++; m_opc_cyc = cyc; end
        if (ADDR_VLD)  m_addr++;
        if (FRAME_END) m_fend++;
        if (FRAME_ERR) m_ferr++;
        if ((int'(CS_FALL) + int'(OPC_VLD) + int'(ADDR_VLD) + int'(FRAME_END)) > 1
            || (FRAME_ERR && !FRAME_END)) m_ovl++;
        if (opc_vld1)   m1_opc++;
        if (addr_vld1)  m1_addr++;
        if (frame_end1) m1_fend++;
        if (frame_err1) m1_ferr++;
        if ((int'(cs_fall1) + int'(opc_vld1) + int'(addr_vld1) + int'(frame_end1)) > 1
            || (frame_err1 && !frame_end1)) m1_ovl++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- frame model ----------------
    bit fb[$];
    int last_rise_cyc, rise8_cyc, frame_no;

    logic [7:0]  exp_opc = '0, exp_opc1 = '0;
    logic [23:0] exp_addr = '0, exp_addr1 = '0;
    logic [7:0]  exp_dcnt = '0, exp_dcnt1 = '0;
    int e_opc, e_addr, e_fend, e_ferr, e1_opc, e1_addr, e1_fend, e1_ferr;
    int s_csf, s_opc, s_addr, s_fend, s_ferr, s_ovl;
    int s1_opc, s1_addr, s1_fend, s1_ferr, s1_ovl;

    task automatic push_byte(input logic [7:0] v);
        for (int b = 7; b >= 0; b--) fb.push_back(v[b]);
    endtask

    // Outcome of a frame of which the first 'eff' bits were received.
    function automatic void predict(input int eff, input int aw, input bit aborted,
                                    inout logic [7:0] opc, inout logic [23:0] addr,
                                    output logic [7:0] dcnt,
                                    output int n_opc, output int n_addr,
                                    output int n_fend, output int n_ferr);
        int v;
        n_opc  = (eff >= 8) ? 1 : 0;
        n_addr = (eff >= 8 + 8 * aw) ? 1 : 0;
        if (n_opc != 0) begin
            v = 0;
            for (int k = 0; k < 8; k++) v = v * 2 + int'(fb[k]);
            opc = 8'(v);
        end
        if (n_addr != 0) begin
            v = 0;
            for (int k = 0; k < 8 * aw; k++) v = v * 2 + int'(fb[8 + k]);
            addr = 24'(v);
            v = (eff - 8 - 8 * aw) / 8;
            dcnt = (v > 255) ? 8'd255 : 8'(v);
        end else begin
            dcnt = 8'd0;
        end
        n_fend = aborted ? 0 : 1;
        n_ferr = (!aborted && (eff % 8) != 0) ? 1 : 0;
    endfunction

    // ---------------- stimulus ----------------
    task automatic spi_bit(input bit b, input int half);
        SPI_MOSI = b;
        repeat (half) @(negedge CLK160M);
        SPI_CLK = 1'b1;
        last_rise_cyc = cyc;
        repeat (half) @(negedge CLK160M);
        SPI_CLK = 1'b0;
    endtask

    task automatic drive_frame(input int half, input bit coinc, input int abort_at);
        SPI_CS = 1'b0;
        repeat (half) @(negedge CLK160M);
        for (int i = 0; i < fb.size(); i++) begin
            if (i == abort_at) EN = 1'b0;
            if (coinc && i == fb.size() - 1) begin
                SPI_MOSI = fb[i];
                repeat (half) @(negedge CLK160M);
                SPI_CLK = 1'b1;
                SPI_CS  = 1'b1;
                last_rise_cyc = cyc;
                repeat (half) @(negedge CLK160M);
                SPI_CLK = 1'b0;
            end else begin
                spi_bit(fb[i], half);
            end
            if (i == 7) rise8_cyc = last_rise_cyc;
        end
        if (!(coinc && fb.size() > 0)) begin
            repeat (half) @(negedge CLK160M);
            if (abort_at >= 0) begin
                EN = 1'b1;
                repeat (4) @(negedge CLK160M);
            end
            SPI_CS = 1'b1;
        end
        repeat (8) @(negedge CLK160M);
    endtask

    task automatic do_frame(input int half, input bit coinc, input int abort_at);
        int eff;
        bit ab;
        ab  = (abort_at >= 0);
        eff = ab ? abort_at : ((coinc && fb.size() > 0) ? fb.size() - 1 : fb.size());
        s_csf = m_csf; s_opc = m_opc; s_addr = m_addr; s_fend = m_fend;
        s_ferr = m_ferr; s_ovl = m_ovl;
        s1_opc = m1_opc; s1_addr = m1_addr; s1_fend = m1_fend;
        s1_ferr = m1_ferr; s1_ovl = m1_ovl;
        predict(eff, 3, ab, exp_opc, exp_addr, exp_dcnt, e_opc, e_addr, e_fend, e_ferr);
        predict(eff, 1, ab, exp_opc1, exp_addr1, exp_dcnt1, e1_opc, e1_addr, e1_fend, e1_ferr);
        drive_frame(half, coinc, abort_at);
        frame_no++;
        $display("frame %0d: bits=%0d half=%0d coinc=%0d abort=%0d opcode=%02h addr=%06h dcnt=%0d end=%0d err=%0d",
                 frame_no, fb.size(), half, coinc, abort_at, OPCODE, ADDR, DATA_CNT,
                 m_fend - s_fend, m_ferr - s_ferr);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        RESET_N = 1'b0;
        repeat (4) @(negedge CLK160M);
        n_cmp++; if ({CS_FALL, OPC_VLD, ADDR_VLD, FRAME_END, FRAME_ERR} !== 5'b0) begin
            n_bad++; $display("FAIL reset_strobes: got %b want 00000", {CS_FALL, OPC_VLD, ADDR_VLD, FRAME_END, FRAME_ERR}); end
        n_cmp++; if (OPCODE !== 8'h00) begin n_bad++; $display("FAIL reset_opcode: got %h want 00", OPCODE); end
        n_cmp++; if (ADDR !== 24'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 000000", ADDR); end
        n_cmp++; if (DATA_CNT !== 8'h0) begin n_bad++; $display("FAIL reset_dcnt: got %h want 00", DATA_CNT); end
        RESET_N = 1'b1;
        repeat (8) @(negedge CLK160M);
        n_cmp++; if (m_csf !== 0) begin n_bad++; $display("FAIL reset_idle_csfall: got %0d want 0", m_csf); end
    endtask

    task automatic test_basic;
        fb.delete();
        push_byte(8'h13); push_byte(8'h00); push_byte(8'h12); push_byte(8'h34);
        do_frame(2, 1'b0, -1);
        n_cmp++; if (m_csf - s_csf !== 1) begin n_bad++; $display("FAIL basic_csfall: got %0d want 1", m_csf - s_csf); end
        n_cmp++; if (m_opc - s_opc !== 1) begin n_bad++; $display("FAIL basic_opcvld: got %0d want 1", m_opc - s_opc); end
        n_cmp++; if (m_opc_cyc - rise8_cyc !== 4) begin n_bad++; $display("FAIL basic_latency: got %0d want 4", m_opc_cyc - rise8_cyc); end
        n_cmp++; if (OPCODE !== 8'h13) begin n_bad++; $display("FAIL basic_opcode: got %h want 13", OPCODE); end
        n_cmp++; if (m_addr - s_addr !== 1) begin n_bad++; $display("FAIL basic_addrvld: got %0d want 1", m_addr - s_addr); end
        n_cmp++; if (ADDR !== 24'h001234) begin n_bad++; $display("FAIL basic_addr: got %h want 001234", ADDR); end
        n_cmp++; if (DATA_CNT !== 8'd0) begin n_bad++; $display("FAIL basic_dcnt: got %0d want 0", DATA_CNT); end
        n_cmp++; if (m_fend - s_fend !== 1 || m_ferr - s_ferr !== 0) begin n_bad++;
            $display("FAIL basic_end: got end=%0d err=%0d want end=1 err=0", m_fend - s_fend, m_ferr - s_ferr); end
        n_cmp++; if (m_ovl - s_ovl !== 0) begin n_bad++; $display("FAIL basic_overlap: got %0d want 0", m_ovl - s_ovl); end
    endtask

    task automatic test_short;
        logic [7:0] b;
        b = 8'h0F;
        fb.delete();
        for (int k = 7; k >= 3; k--) fb.push_back(b[k]);
        do_frame(3, 1'b0, -1);
        n_cmp++; if (m_opc - s_opc !== 0) begin n_bad++; $display("FAIL short_opcvld: got %0d want 0", m_opc - s_opc); end
        n_cmp++; if (OPCODE !== 8'h13) begin n_bad++; $display("FAIL short_opcode: got %h want 13", OPCODE); end
        n_cmp++; if (ADDR !== 24'h001234) begin n_bad++; $display("FAIL short_addr: got %h want 001234", ADDR); end
        n_cmp++; if (m_fend - s_fend !== 1 || m_ferr - s_ferr !== 1) begin n_bad++;
            $display("FAIL short_end: got end=%0d err=%0d want end=1 err=1", m_fend - s_fend, m_ferr - s_ferr); end
    endtask

    task automatic test_saturate;
        fb.delete();
        push_byte(8'h02); push_byte(8'h00); push_byte(8'h01); push_byte(8'h00);
        for (int k = 0; k < 300; k++) push_byte(8'($urandom));
        do_frame(2, 1'b0, -1);
        n_cmp++; if (DATA_CNT !== 8'd255) begin n_bad++; $display("FAIL sat_dcnt: got %0d want 255", DATA_CNT); end
        n_cmp++; if (ADDR !== 24'h000100) begin n_bad++; $display("FAIL sat_addr: got %h want 000100", ADDR); end
        n_cmp++; if (m_fend - s_fend !== 1 || m_ferr - s_ferr !== 0) begin n_bad++;
            $display("FAIL sat_end: got end=%0d err=%0d want end=1 err=0", m_fend - s_fend, m_ferr - s_ferr); end
    endtask

    task automatic test_en_abort;
        fb.delete();
        push_byte(8'h9C); push_byte(8'h55); push_byte(8'hAA);
        do_frame(2, 1'b0, 12);
        n_cmp++; if (m_fend - s_fend !== 0 || m1_fend - s1_fend !== 0) begin n_bad++;
            $display("FAIL abort_fend: got %0d/%0d want 0/0", m_fend - s_fend, m1_fend - s1_fend); end
        n_cmp++; if (OPCODE !== 8'h9C) begin n_bad++; $display("FAIL abort_opcode: got %h want 9c", OPCODE); end
        fb.delete();
        push_byte(8'h10); push_byte(8'h00); push_byte(8'h00); push_byte(8'h80);
        do_frame(2, 1'b0, -1);
        n_cmp++; if (m_csf - s_csf !== 1) begin n_bad++; $display("FAIL rearm_csfall: got %0d want 1", m_csf - s_csf); end
        n_cmp++; if (OPCODE !== 8'h10) begin n_bad++; $display("FAIL rearm_opcode: got %h want 10", OPCODE); end
        n_cmp++; if (ADDR !== 24'h000080) begin n_bad++; $display("FAIL rearm_addr: got %h want 000080", ADDR); end
        n_cmp++; if (m_fend - s_fend !== 1) begin n_bad++; $display("FAIL rearm_fend: got %0d want 1", m_fend - s_fend); end
    endtask

    task automatic test_coincident;
        fb.delete();
        push_byte(8'h03); push_byte(8'hA7);
        do_frame(2, 1'b1, -1);
        n_cmp++; if (m1_addr - s1_addr !== 0) begin n_bad++; $display("FAIL coinc_addrvld1: got %0d want 0", m1_addr - s1_addr); end
        n_cmp++; if (addr1 !== exp_addr1) begin n_bad++; $display("FAIL coinc_addr1: got %h want %h", addr1, exp_addr1); end
        n_cmp++; if (m1_fend - s1_fend !== 1 || m1_ferr - s1_ferr !== 1) begin n_bad++;
            $display("FAIL coinc_end1: got end=%0d err=%0d want end=1 err=1", m1_fend - s1_fend, m1_ferr - s1_ferr); end
        n_cmp++; if (m_ferr - s_ferr !== 1) begin n_bad++; $display("FAIL coinc_err: got %0d want 1", m_ferr - s_ferr); end
        n_cmp++; if (OPCODE !== 8'h03) begin n_bad++; $display("FAIL coinc_opcode: got %h want 03", OPCODE); end
    endtask

    task automatic test_reset_mid_frame;
        logic [15:0] w;
        w = 16'hA53C;
        SPI_CS = 1'b0;
        repeat (2) @(negedge CLK160M);
        for (int i = 0; i < 10; i++) spi_bit(w[15 - i], 2);
        #1 RESET_N = 1'b0;
        #1;
        n_cmp++; if (OPCODE !== 8'h00 || ADDR !== 24'h0) begin n_bad++;
            $display("FAIL rstmid_clear: got opcode=%h addr=%h want 00/000000", OPCODE, ADDR); end
        @(negedge CLK160M);
        for (int i = 10; i < 13; i++) spi_bit(w[15 - i], 2);
        RESET_N = 1'b1;
        s_csf = m_csf; s_opc = m_opc; s_addr = m_addr; s_fend = m_fend;
        for (int i = 0; i < 19; i++) spi_bit(1'($urandom), 2);
        repeat (2) @(negedge CLK160M);
        SPI_CS = 1'b1;
        repeat (8) @(negedge CLK160M);
        n_cmp++; if (m_csf + m_opc + m_addr + m_fend - s_csf - s_opc - s_addr - s_fend !== 0) begin n_bad++;
            $display("FAIL rstmid_strobes: got csf=%0d opc=%0d addr=%0d end=%0d want 0", m_csf - s_csf,
                     m_opc - s_opc, m_addr - s_addr, m_fend - s_fend); end
        exp_opc = '0; exp_opc1 = '0; exp_addr = '0; exp_addr1 = '0;
        fb.delete();
        push_byte(8'hD8); push_byte(8'h00); push_byte(8'h00); push_byte(8'h40);
        do_frame(2, 1'b0, -1);
        n_cmp++; if (OPCODE !== 8'hD8) begin n_bad++; $display("FAIL rstmid_opcode: got %h want d8", OPCODE); end
        n_cmp++; if (ADDR !== 24'h000040) begin n_bad++; $display("FAIL rstmid_addr: got %h want 000040", ADDR); end
        n_cmp++; if (m_fend - s_fend !== 1 || m_ferr - s_ferr !== 0) begin n_bad++;
            $display("FAIL rstmid_end: got end=%0d err=%0d want 1/0", m_fend - s_fend, m_ferr - s_ferr); end
    endtask

    task automatic test_random;
        int nb, half;
        bit co;
        for (int f = 0; f < 24; f++) begin
            nb   = (f < 6) ? (f * 8 + ((f % 2) * 8)) : $urandom_range(0, 72);
            half = $urandom_range(2, 4);
            co   = ($urandom_range(0, 3) == 0) && (nb > 0);
            fb.delete();
            for (int k = 0; k < nb; k++) fb.push_back(1'($urandom));
            do_frame(half, co, -1);
            n_cmp++; if (m_opc - s_opc !== e_opc || OPCODE !== exp_opc) begin n_bad++;
                $display("FAIL rnd%0d_opcode: got n=%0d val=%h want n=%0d val=%h", f, m_opc - s_opc, OPCODE, e_opc, exp_opc); end
            n_cmp++; if (m_addr - s_addr !== e_addr || ADDR !== exp_addr) begin n_bad++;
                $display("FAIL rnd%0d_addr: got n=%0d val=%h want n=%0d val=%h", f, m_addr - s_addr, ADDR, e_addr, exp_addr); end
            n_cmp++; if (DATA_CNT !== exp_dcnt) begin n_bad++;
                $display("FAIL rnd%0d_dcnt: got %0d want %0d", f, DATA_CNT, exp_dcnt); end
            n_cmp++; if (m_fend - s_fend !== e_fend || m_ferr - s_ferr !== e_ferr || m_csf - s_csf !== 1) begin n_bad++;
                $display("FAIL rnd%0d_end: got csf=%0d end=%0d err=%0d want 1/%0d/%0d", f, m_csf - s_csf,
                         m_fend - s_fend, m_ferr - s_ferr, e_fend, e_ferr); end
            n_cmp++; if (m1_addr - s1_addr !== e1_addr || addr1 !== exp_addr1 || data_cnt1 !== exp_dcnt1
                         || opcode1 !== exp_opc1) begin n_bad++;
                $display("FAIL rnd%0d_dut1: got n=%0d addr=%h dcnt=%0d opc=%h want n=%0d addr=%h dcnt=%0d opc=%h", f,
                         m1_addr - s1_addr, addr1, data_cnt1, opcode1, e1_addr, exp_addr1, exp_dcnt1, exp_opc1); end
            n_cmp++; if (m1_ferr - s1_ferr !== e1_ferr || m1_fend - s1_fend !== e1_fend) begin n_bad++;
                $display("FAIL rnd%0d_end1: got end=%0d err=%0d want %0d/%0d", f, m1_fend - s1_fend,
                         m1_ferr - s1_ferr, e1_fend, e1_ferr); end
            n_cmp++; if (m_ovl - s_ovl !== 0 || m1_ovl - s1_ovl !== 0) begin n_bad++;
                $display("FAIL rnd%0d_overlap: got %0d/%0d want 0/0", f, m_ovl - s_ovl, m1_ovl - s1_ovl); end
        end
    endtask

    initial begin
        frame_no = 0;
        @(negedge CLK160M);
        test_reset;
        test_basic;
        test_short;
        test_saturate;
        test_en_abort;
        test_coincident;
        test_reset_mid_frame;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
